// File: rtl/seq_detect.sv
// Serial pattern detector: Moore FSM tracking the longest matched prefix of PATTERN.
// Optional saturating match counter enabled by defining SEQ_DETECT_CNT_EN.
module seq_detect #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int unsigned      OVERLAP = 1,
  localparam int unsigned     SW      = $clog2(PAT_W + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          w,
  input  logic          en,
  output logic [SW-1:0] State,
  output logic          z
`ifdef SEQ_DETECT_CNT_EN
  ,
  output logic [7:0]    match_cnt
`endif
);

  localparam logic [SW-1:0] FULL = SW'(PAT_W);

  // Longest prefix of PATTERN that is a suffix of (prefix of length k, then b).
  // Bit i of the prefix is PATTERN[PAT_W-1-i] since the MSB arrives first.
  function automatic int unsigned fallback(input int unsigned k, input logic b);
    int unsigned best;
    int unsigned lim;
    int unsigned p;
    logic        ok;
    logic        sb;
    best = 0;
    lim  = (k + 1 > PAT_W) ? PAT_W : k + 1;
    for (int unsigned j = 1; j <= lim; j++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < j; i++) begin
        p = k + 1 - j + i;
        if (p == k) sb = b;
        else        sb = PATTERN[PAT_W-1-p];
        if (sb != PATTERN[PAT_W-1-i]) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  function automatic logic [(PAT_W+1)*SW-1:0] build(input logic b);
    logic [(PAT_W+1)*SW-1:0] t;
    int unsigned             nx;
    t = '0;
    for (int unsigned k = 0; k <= PAT_W; k++) begin
      if (k == PAT_W && OVERLAP == 0) nx = (b == PATTERN[PAT_W-1]) ? 1 : 0;
      else                            nx = fallback(k, b);
      t[k*SW +: SW] = SW'(nx);
    end
    return t;
  endfunction

  localparam logic [(PAT_W+1)*SW-1:0] TBL0 = build(1'b0);
  localparam logic [(PAT_W+1)*SW-1:0] TBL1 = build(1'b1);

  logic [SW-1:0] nxt;

  always_comb begin
    nxt = State;
    if (en) begin
      if (State > FULL) nxt = '0;
      else if (w)       nxt = TBL1[State*SW +: SW];
      else              nxt = TBL0[State*SW +: SW];
    end
  end

  // z is registered from the next state so it always equals (State == PAT_W).
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      State <= '0;
      z     <= 1'b0;
`ifdef SEQ_DETECT_CNT_EN
      match_cnt <= '0;
`endif
    end else begin
      State <= nxt;
      z     <= (nxt == FULL);
`ifdef SEQ_DETECT_CNT_EN
      if (en && nxt == FULL && match_cnt != '1) match_cnt <= match_cnt + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: overlapping, non-overlapping and 1111 instances
// share one stimulus stream; the counter section builds only with SEQ_DETECT_CNT_EN.
module tb_seq_detect;

  logic       clk;
  logic       rst;
  logic       w;
  logic       en;
  logic [2:0] st_def, st_nov, st_one;
  logic       z_def, z_nov, z_one;
`ifdef SEQ_DETECT_CNT_EN
  logic [7:0] cnt_def, cnt_nov, cnt_one;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  seq_detect u_def (
    .clk(clk), .Reset(rst), .w(w), .en(en), .State(st_def), .z(z_def)
`ifdef SEQ_DETECT_CNT_EN
    , .match_cnt(cnt_def)
`endif
  );

  seq_detect #(.OVERLAP(0)) u_nov (
    .clk(clk), .Reset(rst), .w(w), .en(en), .State(st_nov), .z(z_nov)
`ifdef SEQ_DETECT_CNT_EN
    , .match_cnt(cnt_nov)
`endif
  );

  seq_detect #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1)) u_one (
    .clk(clk), .Reset(rst), .w(w), .en(en), .State(st_one), .z(z_one)
`ifdef SEQ_DETECT_CNT_EN
    , .match_cnt(cnt_one)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, want completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic e, input logic b);
    @(negedge clk);
    en = e;
    w  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       w;
    logic [2:0] s_def;
    logic [2:0] s_nov;
    logic [2:0] s_one;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 3'd1, 3'd1, 3'd1};
    vecs[1]  = '{1'b1, 1'b1, 3'd2, 3'd2, 3'd2};
    vecs[2]  = '{1'b1, 1'b0, 3'd3, 3'd3, 3'd0};
    vecs[3]  = '{1'b1, 1'b1, 3'd4, 3'd4, 3'd1};
    vecs[4]  = '{1'b1, 1'b1, 3'd2, 3'd1, 3'd2};
    vecs[5]  = '{1'b1, 1'b0, 3'd3, 3'd0, 3'd0};
    vecs[6]  = '{1'b1, 1'b1, 3'd4, 3'd1, 3'd1};
    vecs[7]  = '{1'b0, 1'b0, 3'd4, 3'd1, 3'd1};
    vecs[8]  = '{1'b0, 1'b1, 3'd4, 3'd1, 3'd1};
    vecs[9]  = '{1'b1, 1'b1, 3'd2, 3'd2, 3'd2};
    vecs[10] = '{1'b1, 1'b1, 3'd2, 3'd2, 3'd3};
    vecs[11] = '{1'b1, 1'b1, 3'd2, 3'd2, 3'd4};
    vecs[12] = '{1'b1, 1'b1, 3'd2, 3'd2, 3'd4};
    vecs[13] = '{1'b1, 1'b0, 3'd3, 3'd3, 3'd0};
    vecs[14] = '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0};

    rst = 1'b1;
    en  = 1'b0;
    w   = 1'b0;
    #2;
    chk("reset def state", 32'(st_def), 0);
    chk("reset def z",     32'(z_def),  0);
    chk("reset nov state", 32'(st_nov), 0);
    chk("reset one z",     32'(z_one),  0);
    @(negedge clk);
    rst = 1'b0;

    // Shared-stream table: overlap, non-overlap and 1111 self-overlap
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].en, vecs[i].w);
      chk($sformatf("vec%0d def state", i), 32'(st_def), 32'(vecs[i].s_def));
      chk($sformatf("vec%0d def z", i),     32'(z_def),  32'(vecs[i].s_def == 3'd4));
      chk($sformatf("vec%0d nov state", i), 32'(st_nov), 32'(vecs[i].s_nov));
      chk($sformatf("vec%0d nov z", i),     32'(z_nov),  32'(vecs[i].s_nov == 3'd4));
      chk($sformatf("vec%0d one state", i), 32'(st_one), 32'(vecs[i].s_one));
      chk($sformatf("vec%0d one z", i),     32'(z_one),  32'(vecs[i].s_one == 3'd4));
    end

    // 1111 from S0: z high on the 4th and 5th samples
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      apply(1'b1, 1'b1);
      chk($sformatf("ones%0d state", i), 32'(st_one), (i >= 4) ? 4 : i);
      chk($sformatf("ones%0d z", i),     32'(z_one),  (i >= 4) ? 1 : 0);
    end

    // Enable hold in S3 with w toggling
    do_reset();
    apply(1'b1, 1'b1);
    apply(1'b1, 1'b1);
    apply(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, i[0] ? 1'b0 : 1'b1);
      chk($sformatf("hold%0d state", i), 32'(st_def), 3);
      chk($sformatf("hold%0d z", i),     32'(z_def),  0);
    end
    apply(1'b1, 1'b1);
    chk("hold resume state", 32'(st_def), 4);
    chk("hold resume z",     32'(z_def),  1);

    // Asynchronous reset pulse between edges while in S4 (z high)
    #2;
    rst = 1'b1;
    #1;
    chk("async S4 state", 32'(st_def), 0);
    chk("async S4 z",     32'(z_def),  0);
    rst = 1'b0;

    // Async reset from S3, then a full match afterwards
    apply(1'b1, 1'b1);
    apply(1'b1, 1'b1);
    apply(1'b1, 1'b0);
    chk("pre-async S3 state", 32'(st_def), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async S3 state", 32'(st_def), 0);
    chk("async S3 z",     32'(z_def),  0);
    rst = 1'b0;
    apply(1'b1, 1'b1);
    chk("after async s1", 32'(st_def), 1);
    apply(1'b1, 1'b1);
    apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    chk("after async state", 32'(st_def), 4);
    chk("after async z",     32'(z_def),  1);

    // Reset held across an enabled edge wins over en
    apply(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    w   = 1'b1;
    @(posedge clk);
    #1;
    chk("rst prio state", 32'(st_def), 0);
    chk("rst prio one",   32'(st_one), 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

`ifdef SEQ_DETECT_CNT_EN
    do_reset();
    chk("cnt reset", 32'(cnt_one), 0);
    for (int i = 1; i <= 300; i++) begin
      apply(1'b1, 1'b1);
      if (i == 4)  chk("cnt first", 32'(cnt_one), 1);
      if (i == 13) chk("cnt ten",   32'(cnt_one), 10);
      if (i == 258) chk("cnt sat reach", 32'(cnt_one), 255);
    end
    chk("cnt sat hold", 32'(cnt_one), 255);
    chk("cnt def none", 32'(cnt_def), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("cnt async clr", 32'(cnt_one), 0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
